sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 19 +
 rtl/sdram_arb_pend_fifo.sv | 47 ++++
 rtl/sdram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types for the two-port SDRAM arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA
  } arb_state_t;

  // Pending entries keep the burst length at a fixed width so the FIFO word is
  // independent of the arbiter's BURST_W (which must not exceed this).
  localparam int PEND_BC_W = 16;

  typedef struct packed {
    logic                 id;
    logic [PEND_BC_W-1:0] burstcount;
  } pend_entry_t;

endpackage

// File: rtl/sdram_arb_pend_fifo.sv
// rtl/sdram_arb_pend_fifo.sv - outstanding read-burst FIFO, head visible without latency
module sdram_arb_pend_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin two-requester arbiter onto one Avalon-MM SDRAM port
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 32,
  parameter int BURST_W    = 8,
  parameter int PEND_DEPTH = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [2*ADDR_W-1:0]   rq_address,
  input  logic [1:0]            rq_read,
  input  logic [1:0]            rq_write,
  input  logic [2*DATA_W-1:0]   rq_writedata,
  input  logic [2*DATA_W/8-1:0] rq_byteenable,
  input  logic [2*BURST_W-1:0]  rq_burstcount,
  output logic [1:0]            rq_waitrequest,
  output logic [DATA_W-1:0]     rq_readdata,
  output logic [1:0]            rq_readdatavalid,
  output logic [ADDR_W-1:0]     sdram_address,
  output logic                  sdram_read,
  output logic                  sdram_write,
  output logic [DATA_W-1:0]     sdram_writedata,
  output logic [DATA_W/8-1:0]   sdram_byteenable,
  output logic [BURST_W-1:0]    sdram_burstcount,
  input  logic                  sdram_waitrequest,
  input  logic [DATA_W-1:0]     sdram_readdata,
  input  logic                  sdram_readdatavalid,
  output logic                  err_orphan
);
  localparam int BE_W = DATA_W / 8;

  arb_state_t           state;
  logic                 grant;
  logic                 last_grant;
  logic [BURST_W-1:0]   beat_cnt;
  logic [PEND_BC_W-1:0] rd_cnt;

  logic [1:0]           req;
  logic                 pick;
  logic                 sel_read;
  logic                 sel_write;
  logic [BURST_W-1:0]   sel_bc;
  logic                 is_cmd_rd;
  logic                 rd_acc;
  logic                 wr_acc;

  pend_entry_t          push_entry;
  pend_entry_t          head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [PEND_BC_W-1:0] head_len;
  logic                 head_last;
  logic                 beat_ok;

  assign req       = rq_read | rq_write;
  assign pick      = (req == 2'b11) ? ~last_grant : req[1];

  assign sel_read         = rq_read[grant];
  assign sel_write        = rq_write[grant];
  assign sel_bc           = grant ? rq_burstcount[2*BURST_W-1:BURST_W] : rq_burstcount[BURST_W-1:0];
  assign sdram_address    = grant ? rq_address[2*ADDR_W-1:ADDR_W] : rq_address[ADDR_W-1:0];
  assign sdram_writedata  = grant ? rq_writedata[2*DATA_W-1:DATA_W] : rq_writedata[DATA_W-1:0];
  assign sdram_byteenable = grant ? rq_byteenable[2*BE_W-1:BE_W] : rq_byteenable[BE_W-1:0];
  assign sdram_burstcount = sel_bc;

  // A read request takes precedence over a simultaneous write from the same requester.
  assign is_cmd_rd   = (state == ST_CMD) && sel_read;
  assign sdram_read  = is_cmd_rd && !fifo_full;
  assign sdram_write = ((state == ST_CMD) && !sel_read && sel_write) ||
                       ((state == ST_WDATA) && sel_write);
  assign rd_acc      = sdram_read && !sdram_waitrequest;
  assign wr_acc      = sdram_write && !sdram_waitrequest;

  always_comb begin
    rq_waitrequest = 2'b11;
    if (state != ST_IDLE)
      rq_waitrequest[grant] = sdram_waitrequest || (is_cmd_rd && fifo_full);
  end

  assign push_entry = '{id: grant, burstcount: PEND_BC_W'(sel_bc)};
  assign head_len   = (head.burstcount == '0) ? PEND_BC_W'(1) : head.burstcount;
  assign head_last  = (rd_cnt == head_len - PEND_BC_W'(1));
  assign beat_ok    = sdram_readdatavalid && !fifo_empty;

  assign rq_readdata      = sdram_readdata;
  assign rq_readdatavalid = beat_ok ? (head.id ? 2'b10 : 2'b01) : 2'b00;

  sdram_arb_pend_fifo #(
    .W     ($bits(pend_entry_t)),
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .push  (rd_acc),
    .din   (push_entry),
    .pop   (beat_ok && head_last),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      rd_cnt     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (sdram_readdatavalid) begin
        if (fifo_empty) err_orphan <= 1'b1;
        else            rd_cnt     <= head_last ? '0 : rd_cnt + PEND_BC_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (sel_read) begin
            if (rd_acc) state <= ST_IDLE;
          end else if (sel_write) begin
            if (wr_acc) begin
              if (sel_bc <= BURST_W'(1)) begin
                state <= ST_IDLE;
              end else begin
                beat_cnt <= sel_bc - BURST_W'(1);
                state    <= ST_WDATA;
              end
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (wr_acc) begin
            beat_cnt <= beat_cnt - BURST_W'(1);
            if (beat_cnt <= BURST_W'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  localparam int AW = 29;
  localparam int DW = 32;
  localparam int BW = 8;

  logic            clk_clk = 1'b0;
  logic            reset_reset = 1'b1;
  logic [2*AW-1:0] rq_address = '0;
  logic [1:0]      rq_read = '0;
  logic [1:0]      rq_write = '0;
  logic [2*DW-1:0] rq_writedata = '0;
  logic [7:0]      rq_byteenable = '1;
  logic [2*BW-1:0] rq_burstcount = '0;
  logic [1:0]      rq_waitrequest;
  logic [DW-1:0]   rq_readdata;
  logic [1:0]      rq_readdatavalid;
  logic [AW-1:0]   sdram_address;
  logic            sdram_read;
  logic            sdram_write;
  logic [DW-1:0]   sdram_writedata;
  logic [3:0]      sdram_byteenable;
  logic [BW-1:0]   sdram_burstcount;
  logic            sdram_waitrequest = 1'b0;
  logic [DW-1:0]   sdram_readdata = '0;
  logic            sdram_readdatavalid = 1'b0;
  logic            err_orphan;

  int checks = 0;
  int errors = 0;
  bit hold_data = 1'b0;
  bit inject_orphan = 1'b0;
  int wait1_viol = 0;
  int beats_to [2];
  logic [DW-1:0] beat_q [$];
  bit            exp_id [$];
  logic [DW-1:0] exp_data [$];
  logic [DW-1:0] wr_got [$];

  always #5 clk_clk = ~clk_clk;

  sdram_port_arbiter dut (
    .clk_clk             (clk_clk),
    .reset_reset         (reset_reset),
    .rq_address          (rq_address),
    .rq_read             (rq_read),
    .rq_write            (rq_write),
    .rq_writedata        (rq_writedata),
    .rq_byteenable       (rq_byteenable),
    .rq_burstcount       (rq_burstcount),
    .rq_waitrequest      (rq_waitrequest),
    .rq_readdata         (rq_readdata),
    .rq_readdatavalid    (rq_readdatavalid),
    .sdram_address       (sdram_address),
    .sdram_read          (sdram_read),
    .sdram_write         (sdram_write),
    .sdram_writedata     (sdram_writedata),
    .sdram_byteenable    (sdram_byteenable),
    .sdram_burstcount    (sdram_burstcount),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .err_orphan          (err_orphan)
  );

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a, input int b);
    return {4'h0, a[19:0], 8'(b)} ^ 32'hA500_0000;
  endfunction

  function automatic logic [DW-1:0] wd_word(input bit id, input logic [AW-1:0] a, input int b);
    return {id, 3'h0, a[19:0], 8'(b)};
  endfunction

  // SDRAM side: capture handshakes at negedge, return read beats at posedge+1.
  initial begin
    forever begin
      @(posedge clk_clk);
      #1;
      if (inject_orphan) begin
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 32'hDEAD_0000;
        inject_orphan       = 1'b0;
      end else if (!hold_data && beat_q.size() > 0) begin
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = beat_q.pop_front();
      end else begin
        sdram_readdatavalid = 1'b0;
      end
    end
  end

  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (sdram_read && !sdram_waitrequest) begin
        for (int b = 0; b < ((sdram_burstcount == 0) ? 1 : int'(sdram_burstcount)); b++)
          beat_q.push_back(rd_word(sdram_address, b));
      end
      if (sdram_write && !sdram_waitrequest) begin
        wr_got.push_back(sdram_writedata);
        if (!sdram_writedata[31] && rq_waitrequest[1] !== 1'b1) wait1_viol++;
      end
      if (rq_readdatavalid !== 2'b00) begin
        checks++;
        if (exp_id.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat valid=%b data=%h, none expected", rq_readdatavalid, rq_readdata);
        end else begin
          bit eid;
          logic [DW-1:0] ed;
          eid = exp_id.pop_front();
          ed  = exp_data.pop_front();
          if (rq_readdatavalid !== (eid ? 2'b10 : 2'b01) || rq_readdata !== ed) begin
            errors++;
            $display("FAIL read_beat valid=%b data=%h, expected id=%0d data=%h",
                     rq_readdatavalid, rq_readdata, eid, ed);
          end
          beats_to[eid]++;
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk_clk); #1;
    reset_reset = 1'b1;
    rq_read = '0;
    rq_write = '0;
    sdram_waitrequest = 1'b0;
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    beat_q.delete();
    exp_id.delete();
    exp_data.delete();
    wr_got.delete();
  endtask

  task automatic issue_read(input bit id, input logic [AW-1:0] a, input int bc);
    bit ok = 1'b0;
    @(posedge clk_clk); #1;
    rq_read[id] = 1'b1;
    rq_address[id*AW +: AW] = a;
    rq_burstcount[id*BW +: BW] = BW'(bc);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_clk);
      if (!rq_waitrequest[id]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL read_accept_timeout id=%0d addr=%h", id, a);
    end else begin
      for (int b = 0; b < ((bc == 0) ? 1 : bc); b++) begin
        exp_id.push_back(id);
        exp_data.push_back(rd_word(a, b));
      end
    end
    @(posedge clk_clk); #1;
    rq_read[id] = 1'b0;
  endtask

  task automatic do_write(input bit id, input logic [AW-1:0] a, input int bc);
    bit ok;
    @(posedge clk_clk); #1;
    rq_write[id] = 1'b1;
    rq_address[id*AW +: AW] = a;
    rq_burstcount[id*BW +: BW] = BW'(bc);
    rq_writedata[id*DW +: DW] = wd_word(id, a, 0);
    for (int b = 0; b < ((bc == 0) ? 1 : bc); b++) begin
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk_clk);
        if (!rq_waitrequest[id]) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL write_accept_timeout id=%0d beat=%0d", id, b);
        break;
      end
      @(posedge clk_clk); #1;
      rq_writedata[id*DW +: DW] = wd_word(id, a, b + 1);
    end
    rq_write[id] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_id.size() > 0; i++) @(negedge clk_clk);
    checks++;
    if (exp_id.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d, expected 0", name, exp_id.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_clk);
    checks += 5;
    if (sdram_read !== 1'b0)         begin errors++; $display("FAIL reset_read got=%b exp=0", sdram_read); end
    if (sdram_write !== 1'b0)        begin errors++; $display("FAIL reset_write got=%b exp=0", sdram_write); end
    if (rq_waitrequest !== 2'b11)    begin errors++; $display("FAIL reset_wait got=%b exp=11", rq_waitrequest); end
    if (rq_readdatavalid !== 2'b00)  begin errors++; $display("FAIL reset_rdv got=%b exp=00", rq_readdatavalid); end
    if (err_orphan !== 1'b0)         begin errors++; $display("FAIL reset_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_single_read();
    beats_to[0] = 0; beats_to[1] = 0;
    @(posedge clk_clk); #1;
    rq_read[0] = 1'b1;
    rq_address[AW-1:0] = AW'('h100);
    rq_burstcount[BW-1:0] = 8'd4;
    @(negedge clk_clk);
    checks++;
    if (sdram_read !== 1'b0) begin errors++; $display("FAIL sr_idle_read got=%b exp=0", sdram_read); end
    @(negedge clk_clk);
    checks += 4;
    if (sdram_read !== 1'b1)        begin errors++; $display("FAIL sr_cmd_read got=%b exp=1", sdram_read); end
    if (sdram_address !== AW'('h100)) begin errors++; $display("FAIL sr_addr got=%h exp=100", sdram_address); end
    if (sdram_burstcount !== 8'd4)  begin errors++; $display("FAIL sr_bc got=%0d exp=4", sdram_burstcount); end
    if (rq_waitrequest !== 2'b10)   begin errors++; $display("FAIL sr_wait got=%b exp=10", rq_waitrequest); end
    for (int b = 0; b < 4; b++) begin
      exp_id.push_back(1'b0);
      exp_data.push_back(rd_word(AW'('h100), b));
    end
    @(posedge clk_clk); #1;
    rq_read[0] = 1'b0;
    wait_drain("single_read");
    checks++;
    if (beats_to[0] != 4 || beats_to[1] != 0) begin
      errors++; $display("FAIL sr_split got=%0d/%0d exp=4/0", beats_to[0], beats_to[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w [4];
    apply_reset();
    wait1_viol = 0;
    exp_w[0] = wd_word(1'b0, AW'('h200), 0);
    exp_w[1] = wd_word(1'b0, AW'('h200), 1);
    exp_w[2] = wd_word(1'b1, AW'('h300), 0);
    exp_w[3] = wd_word(1'b1, AW'('h300), 1);
    fork
      do_write(1'b0, AW'('h200), 2);
      do_write(1'b1, AW'('h300), 2);
    join
    checks++;
    if (wr_got.size() != 4) begin
      errors++; $display("FAIL bb_count got=%0d exp=4", wr_got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_got[i] !== exp_w[i]) begin
          errors++; $display("FAIL bb_beat%0d got=%h exp=%h", i, wr_got[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (wait1_viol != 0) begin errors++; $display("FAIL bb_rq1_wait violations=%0d exp=0", wait1_viol); end
  endtask

  task automatic test_pend_full();
    beats_to[0] = 0; beats_to[1] = 0;
    hold_data = 1'b1;
    for (int i = 0; i < 8; i++) issue_read(1'b1, AW'('h400 + i), 1);
    fork
      issue_read(1'b1, AW'('h500), 1);
      begin
        for (int c = 0; c < 6; c++) begin
          @(negedge clk_clk);
          checks++;
          if (sdram_read !== 1'b0 || rq_waitrequest[1] !== 1'b1) begin
            errors++; $display("FAIL full_stall cyc=%0d read=%b wait=%b exp read=0 wait=1", c, sdram_read, rq_waitrequest[1]);
          end
        end
        checks++;
        if (beat_q.size() != 8) begin errors++; $display("FAIL full_accepted got=%0d exp=8", beat_q.size()); end
        hold_data = 1'b0;
      end
    join
    wait_drain("pend_full");
    checks++;
    if (beats_to[1] != 9) begin errors++; $display("FAIL full_beats got=%0d exp=9", beats_to[1]); end
  endtask

  task automatic test_interleave();
    beats_to[0] = 0; beats_to[1] = 0;
    hold_data = 1'b1;
    fork
      issue_read(1'b0, AW'('h600), 3);
      issue_read(1'b1, AW'('h700), 2);
    join
    hold_data = 1'b0;
    wait_drain("interleave");
    checks++;
    if (beats_to[0] != 3 || beats_to[1] != 2) begin
      errors++; $display("FAIL il_split got=%0d/%0d exp=3/2", beats_to[0], beats_to[1]);
    end
  endtask

  task automatic test_orphan();
    inject_orphan = 1'b1;
    @(posedge clk_clk);
    @(negedge clk_clk);
    checks++;
    if (rq_readdatavalid !== 2'b00) begin errors++; $display("FAIL orphan_rdv got=%b exp=00", rq_readdatavalid); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_clk);
      checks++;
      if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky cyc=%0d got=%b exp=1", c, err_orphan); end
    end
  endtask

  task automatic test_reset_wdata();
    bit ok = 1'b0;
    @(posedge clk_clk); #1;
    rq_write[0] = 1'b1;
    rq_address[AW-1:0] = AW'('h800);
    rq_burstcount[BW-1:0] = 8'd6;
    rq_writedata[DW-1:0] = wd_word(1'b0, AW'('h800), 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_clk);
      if (!rq_waitrequest[0]) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rw_first_beat timeout"); end
    @(posedge clk_clk); #1;
    sdram_waitrequest = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (sdram_write !== 1'b1) begin errors++; $display("FAIL rw_in_burst got=%b exp=1", sdram_write); end
    @(posedge clk_clk); #1;
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    reset_reset = 1'b0;
    rq_write = '0;
    sdram_waitrequest = 1'b0;
    @(negedge clk_clk);
    checks += 3;
    if (sdram_write !== 1'b0)      begin errors++; $display("FAIL rw_write got=%b exp=0", sdram_write); end
    if (rq_waitrequest !== 2'b11)  begin errors++; $display("FAIL rw_wait got=%b exp=11", rq_waitrequest); end
    if (err_orphan !== 1'b0)       begin errors++; $display("FAIL rw_orphan got=%b exp=0", err_orphan); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_pend_full();
    test_interleave();
    test_orphan();
    test_reset_wdata();
    repeat (2) @(negedge clk_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
